// File: rtl/mb_blk_sched.sv
`default_nettype none
// ============================================================================
// Module   : mb_blk_sched
// Purpose  : Per-macroblock 4x4 block scheduler for the coefficient path.
//            Emits one block descriptor at a time in H.264 coding order:
//            [luma DC], 16 luma blocks, [Cb DC, Cr DC, 4x Cb AC, 4x Cr AC].
//            Each descriptor carries the DC flag and the coefficient limit
//            used by the flow-control and CAVLC stages downstream.
// Ports    : clk        - clock, rising edge
//            RESET      - synchronous active-high reset
//            START      - begin macroblock (honoured only when idle)
//            INTRA16    - Intra16x16 macroblock, latched at START
//            CHROMA_EN  - code chroma blocks, latched at START
//            ABORT      - terminate current macroblock
//            BLK_ACK    - downstream accepts current descriptor
//            BLK_VALID  - descriptor valid
//            BLK_TYPE   - 0 L4x4, 1 LDC, 2 LAC, 3 CBDC, 4 CRDC, 5 CBAC, 6 CRAC
//            BLK_IDX    - coding-order index within the type
//            BLK_POS    - raster position of the block
//            DC         - descriptor is a DC block
//            MAX_COEF   - coefficient limit for the block
//            BUSY       - scheduler not idle
//            MB_DONE    - one-cycle pulse after the last descriptor
// Revision : 1.0 - initial release
// ============================================================================
module mb_blk_sched #(
  parameter int LUMA_BLKS   = 16,
  parameter int CHROMA_BLKS = 4,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 INTRA16,
  input  logic                 CHROMA_EN,
  input  logic                 ABORT,
  input  logic                 BLK_ACK,
  output logic                 BLK_VALID,
  output logic [2:0]           BLK_TYPE,
  output logic [3:0]           BLK_IDX,
  output logic [3:0]           BLK_POS,
  output logic                 DC,
  output logic [CNT_WIDTH-1:0] MAX_COEF,
  output logic                 BUSY,
  output logic                 MB_DONE
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDC  = 3'd1,
    S_LUMA = 3'd2,
    S_CDC  = 3'd3,
    S_CAC  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [3:0]           c_LUMA_LAST   = 4'(LUMA_BLKS - 1);
  localparam logic [3:0]           c_CHROMA_LAST = 4'(CHROMA_BLKS - 1);
  localparam logic [CNT_WIDTH-1:0] c_MAX_16      = CNT_WIDTH'(16);
  localparam logic [CNT_WIDTH-1:0] c_MAX_15      = CNT_WIDTH'(15);
  localparam logic [CNT_WIDTH-1:0] c_MAX_4       = CNT_WIDTH'(4);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_idx;
  logic [3:0] w_next_idx;
  // Component select: 0 = Cb, 1 = Cr (used in both chroma DC and AC phases)
  logic       r_comp;
  logic       w_next_comp;
  logic       r_intra16;
  logic       r_chroma_en;
  logic       w_xfer;

  assign w_xfer = BLK_VALID & BLK_ACK;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_comp      <= 1'b0;
      r_intra16   <= 1'b0;
      r_chroma_en <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_comp  <= w_next_comp;
      // Mode flags are captured only on an accepted START so they stay
      // frozen for the whole macroblock.
      if (r_state == S_IDLE && START) begin
        r_intra16   <= INTRA16;
        r_chroma_en <= CHROMA_EN;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_comp  = r_comp;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_next_state = INTRA16 ? S_LDC : S_LUMA;
          w_next_idx   = 4'd0;
          w_next_comp  = 1'b0;
        end
      end
      S_LDC: begin
        if (w_xfer) w_next_state = S_LUMA;
      end
      S_LUMA: begin
        if (w_xfer) begin
          if (r_idx == c_LUMA_LAST) begin
            w_next_idx   = 4'd0;
            w_next_state = r_chroma_en ? S_CDC : S_DONE;
          end else begin
            w_next_idx = r_idx + 4'd1;
          end
        end
      end
      S_CDC: begin
        if (w_xfer) begin
          w_next_comp = ~r_comp;
          if (r_comp) w_next_state = S_CAC;
        end
      end
      S_CAC: begin
        if (w_xfer) begin
          if (r_idx == c_CHROMA_LAST) begin
            w_next_idx  = 4'd0;
            w_next_comp = ~r_comp;
            if (r_comp) w_next_state = S_DONE;
          end else begin
            w_next_idx = r_idx + 4'd1;
          end
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    // Abort outranks any transfer in the same cycle.
    if (ABORT && r_state != S_IDLE) begin
      w_next_state = S_IDLE;
      w_next_idx   = 4'd0;
      w_next_comp  = 1'b0;
    end
  end

  // Descriptor fields are decoded from state so they hold naturally while
  // stalled and read zero whenever no descriptor is being offered.
  always_comb begin
    BLK_VALID = 1'b0;
    BLK_TYPE  = 3'd0;
    BLK_IDX   = 4'd0;
    BLK_POS   = 4'd0;
    DC        = 1'b0;
    MAX_COEF  = '0;
    MB_DONE   = 1'b0;
    case (r_state)
      S_LDC: begin
        BLK_VALID = 1'b1;
        BLK_TYPE  = 3'd1;
        DC        = 1'b1;
        MAX_COEF  = c_MAX_16;
      end
      S_LUMA: begin
        BLK_VALID = 1'b1;
        BLK_TYPE  = r_intra16 ? 3'd2 : 3'd0;
        BLK_IDX   = r_idx;
        // Coding order walks 8x8 quadrants, so swap the middle index bits
        // to get the raster position.
        BLK_POS   = {r_idx[3], r_idx[1], r_idx[2], r_idx[0]};
        MAX_COEF  = r_intra16 ? c_MAX_15 : c_MAX_16;
      end
      S_CDC: begin
        BLK_VALID = 1'b1;
        BLK_TYPE  = r_comp ? 3'd4 : 3'd3;
        DC        = 1'b1;
        MAX_COEF  = c_MAX_4;
      end
      S_CAC: begin
        BLK_VALID = 1'b1;
        BLK_TYPE  = r_comp ? 3'd6 : 3'd5;
        BLK_IDX   = r_idx;
        BLK_POS   = r_idx;
        MAX_COEF  = c_MAX_15;
      end
      S_DONE: begin
        MB_DONE = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign BUSY = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mb_blk_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mb_blk_sched
// Purpose  : Scoreboard bench for mb_blk_sched. A reference model expands
//            each accepted START into the full expected descriptor list
//            plus an end-of-macroblock marker; an independent monitor pops
//            and compares on every transfer and every MB_DONE pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mb_blk_sched;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic       INTRA16 = 1'b0;
  logic       CHROMA_EN = 1'b0;
  logic       ABORT = 1'b0;
  logic       BLK_ACK = 1'b0;
  logic       BLK_VALID;
  logic [2:0] BLK_TYPE;
  logic [3:0] BLK_IDX;
  logic [3:0] BLK_POS;
  logic       DC;
  logic [4:0] MAX_COEF;
  logic       BUSY;
  logic       MB_DONE;

  mb_blk_sched #(.LUMA_BLKS(16), .CHROMA_BLKS(4), .CNT_WIDTH(5)) dut (
    .clk(clk), .RESET(RESET), .START(START), .INTRA16(INTRA16),
    .CHROMA_EN(CHROMA_EN), .ABORT(ABORT), .BLK_ACK(BLK_ACK),
    .BLK_VALID(BLK_VALID), .BLK_TYPE(BLK_TYPE), .BLK_IDX(BLK_IDX),
    .BLK_POS(BLK_POS), .DC(DC), .MAX_COEF(MAX_COEF), .BUSY(BUSY),
    .MB_DONE(MB_DONE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       done;
    logic [2:0] t;
    logic [3:0] idx;
    logic [3:0] pos;
    logic       dc;
    logic [4:0] mx;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  int   start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: expected descriptors straight from the coding-order rules.
  task automatic push_mb(input bit intra, input bit chroma);
    exp_t e;
    if (intra) begin
      e = '0; e.t = 3'd1; e.dc = 1'b1; e.mx = 5'd16; q.push_back(e);
    end
    for (int i = 0; i < 16; i++) begin
      int qd = i / 4;
      int sb = i % 4;
      int x = (qd % 2) * 2 + (sb % 2);
      int y = (qd / 2) * 2 + (sb / 2);
      e = '0;
      e.t = intra ? 3'd2 : 3'd0;
      e.idx = 4'(i);
      e.pos = 4'(y * 4 + x);
      e.mx = intra ? 5'd15 : 5'd16;
      q.push_back(e);
    end
    if (chroma) begin
      e = '0; e.t = 3'd3; e.dc = 1'b1; e.mx = 5'd4; q.push_back(e);
      e = '0; e.t = 3'd4; e.dc = 1'b1; e.mx = 5'd4; q.push_back(e);
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 4; i++) begin
          e = '0;
          e.t = (c == 0) ? 3'd5 : 3'd6;
          e.idx = 4'(i);
          e.pos = 4'(i);
          e.mx = 5'd15;
          q.push_back(e);
        end
    end
    e = '0; e.done = 1'b1; q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  exp_t        m_e;
  logic        p_valid = 1'b0;
  logic        p_ack = 1'b0;
  logic        p_excl = 1'b1;
  logic [16:0] p_desc = '0;

  always @(negedge clk) begin
    if (!RESET) begin
      if (BLK_VALID && BLK_ACK) begin
        if (q.size() == 0) chk("xfer_unexpected", 32'd1, 32'd0);
        else begin
          m_e = q.pop_front();
          chk("desc", {1'b0, BLK_TYPE, BLK_IDX, BLK_POS, DC, MAX_COEF}, m_e);
        end
      end
      if (MB_DONE) begin
        done_cyc = cyc;
        if (q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else begin
          m_e = q.pop_front();
          chk("mb_done_at_end", {31'd0, m_e.done}, 32'd1);
        end
      end
      if (!BLK_VALID) chk("idle_fields_zero", {BLK_TYPE, BLK_IDX, BLK_POS, DC, MAX_COEF}, 32'd0);
      if (p_valid && !p_ack && !p_excl)
        chk("stall_stable", {BLK_VALID, BLK_TYPE, BLK_IDX, BLK_POS, DC, MAX_COEF}, {1'b1, p_desc});
    end
    p_valid = BLK_VALID;
    p_ack   = BLK_ACK;
    p_excl  = RESET | ABORT;
    p_desc  = {BLK_TYPE, BLK_IDX, BLK_POS, DC, MAX_COEF};
  end

  // Issue START from idle; returns at posedge+1 with the first descriptor up.
  task automatic start_mb(input bit intra, input bit chroma);
    START = 1'b1; INTRA16 = intra; CHROMA_EN = chroma;
    push_mb(intra, chroma);
    @(posedge clk); #1;
    START = 1'b0;
    start_cyc = cyc;
  endtask

  // Run until the monitor has consumed the end marker, then check idle.
  // rnd_ack randomises BLK_ACK; noise toggles START/INTRA16/CHROMA_EN;
  // hold_start keeps START high throughout (including the MB_DONE cycle).
  task automatic drain(input bit rnd_ack, input bit noise, input bit hold_start);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (q.size() == 0) break;
      BLK_ACK = rnd_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (noise) begin
        START = ($urandom_range(0, 3) == 0);
        INTRA16 = 1'($urandom);
        CHROMA_EN = 1'($urandom);
      end
      if (hold_start) START = 1'b1;
      @(posedge clk); #1;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    START = 1'b0;
    chk("busy_after_done", {31'd0, BUSY}, 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {BLK_VALID, BLK_TYPE, BLK_IDX, BLK_POS, DC, MAX_COEF, BUSY, MB_DONE}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");
    RESET = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("idle_after_reset");

    // 1: intra16 + chroma, ack held high: 27 back-to-back descriptors
    BLK_ACK = 1'b1;
    start_mb(1'b1, 1'b1);
    drain(1'b0, 1'b0, 1'b0);
    chk("latency_intra_chroma", 32'(done_cyc - start_cyc), 32'd27);

    // 2: plain luma only
    start_mb(1'b0, 1'b0);
    drain(1'b0, 1'b0, 1'b0);
    chk("latency_luma_only", 32'(done_cyc - start_cyc), 32'd16);

    // 3: backpressure on luma idx 3 for 5 cycles
    BLK_ACK = 1'b1;
    start_mb(1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    BLK_ACK = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("stall_idx", {28'd0, BLK_IDX}, 32'd3);
    drain(1'b0, 1'b0, 1'b0);
    chk("latency_stalled", 32'(done_cyc - start_cyc), 32'd31);

    // 4: abort at CB_AC idx 2, then restart
    BLK_ACK = 1'b1;
    start_mb(1'b0, 1'b1);
    repeat (20) begin @(posedge clk); #1; end
    chk("pre_abort_desc", {BLK_TYPE, BLK_IDX}, {3'd5, 4'd2});
    ABORT = 1'b1;
    @(posedge clk); #1;
    ABORT = 1'b0;
    q.delete();
    chk("abort_idle", {BUSY, BLK_VALID, MB_DONE}, 32'd0);
    @(posedge clk); #1;
    chk("abort_no_done", {BUSY, MB_DONE}, 32'd0);
    start_mb(1'b1, 1'b0);
    drain(1'b0, 1'b0, 1'b0);

    // 5: reset mid-luma together with ack and start
    BLK_ACK = 1'b1;
    start_mb(1'b0, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    chk("pre_reset_idx", {28'd0, BLK_IDX}, 32'd7);
    RESET = 1'b1; START = 1'b1;
    @(posedge clk); #1;
    q.delete();
    chk_all_zero("reset_mid_luma");
    RESET = 1'b0; START = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("start_ignored_in_reset");

    // 6: START/INTRA16 noise while busy; START held through MB_DONE
    BLK_ACK = 1'b1;
    start_mb(1'b0, 1'b1);
    drain(1'b0, 1'b1, 1'b0);
    start_mb(1'b1, 1'b0);
    drain(1'b0, 1'b0, 1'b1);
    // START is still honoured one cycle after MB_DONE
    start_mb(1'b0, 1'b1);
    drain(1'b1, 1'b0, 1'b0);

    // Randomised macroblocks with random backpressure and input noise
    for (int n = 0; n < 24; n++) begin
      start_mb(1'($urandom), 1'($urandom));
      drain(1'b1, 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mb_blk_sched.md
Name: mb_blk_sched

Overview:
- Per-macroblock block scheduler for the coefficient path.
- Issues one 4x4-block descriptor at a time, in H.264 coding order: luma DC, 16 luma blocks, chroma DC Cb/Cr, then chroma AC Cb/Cr.
- Supplies the DC flag and the per-block coefficient limit that the downstream flow-control and CAVLC stages consume.
- Sits between the macroblock-level control and the transform/flow-control/entropy pipeline.

Parameters:
- LUMA_BLKS, 16, number of luma 4x4 blocks per macroblock.
- CHROMA_BLKS, 4, number of chroma 4x4 blocks per component.
- CNT_WIDTH, 5, width of MAX_COEF (must hold 16).

Ports:
- clk  in  1  clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  begin macroblock; sampled only in IDLE.
- INTRA16  in  1  macroblock is Intra16x16 (adds luma DC; luma blocks become AC-only); latched at START.
- CHROMA_EN  in  1  code chroma blocks; latched at START.
- ABORT  in  1  terminate current macroblock.
- BLK_ACK  in  1  downstream accepts the current descriptor.
- BLK_VALID  out  1  descriptor valid.
- BLK_TYPE  out  3  0=LUMA4x4, 1=LUMA_DC, 2=LUMA_AC, 3=CB_DC, 4=CR_DC, 5=CB_AC, 6=CR_AC.
- BLK_IDX  out  4  coding-order index within the current type.
- BLK_POS  out  4  raster position (luma: {idx[3],idx[1],idx[2],idx[0]}; chroma: idx; DC: 0).
- DC  out  1  1 for LUMA_DC/CB_DC/CR_DC descriptors.
- MAX_COEF  out  CNT_WIDTH  16 for LUMA4x4/LUMA_DC, 15 for LUMA_AC/CB_AC/CR_AC, 4 for CB_DC/CR_DC.
- BUSY  out  1  state != IDLE.
- MB_DONE  out  1  one-cycle pulse after the last descriptor is accepted.

Behaviour:
- States: IDLE, LDC, LUMA, CDC, CAC, DONE.
- RESET: state = IDLE, counters = 0, latched flags = 0. All outputs are 0 from the cycle after RESET is sampled. RESET overrides START, ABORT and BLK_ACK, including mid-macroblock.
- IDLE:
  - START=1 latches INTRA16 and CHROMA_EN.
  - Next state is LDC if INTRA16=1, otherwise LUMA.
  - The first descriptor is valid on the cycle after START (latency 1).
- Transfer rule:
  - A transfer occurs when BLK_VALID && BLK_ACK.
  - Descriptor outputs are held stable while BLK_VALID=1 and BLK_ACK=0.
  - After a transfer, the next descriptor is presented on the next cycle with no bubble, so BLK_VALID stays 1.
- LDC: one descriptor (LUMA_DC, idx 0). On transfer -> LUMA.
- LUMA:
  - idx counts 0..LUMA_BLKS-1; type is LUMA_AC if INTRA16 else LUMA4x4.
  - On transfer of idx LUMA_BLKS-1 -> CDC if CHROMA_EN, else DONE.
- CDC: two descriptors, CB_DC then CR_DC, idx 0. On transfer of CR_DC -> CAC.
- CAC:
  - CHROMA_BLKS CB_AC descriptors (idx 0..CHROMA_BLKS-1), then CHROMA_BLKS CR_AC descriptors.
  - On transfer of the last CR_AC -> DONE.
- DONE:
  - BLK_VALID=0 and MB_DONE=1 for exactly one cycle, then -> IDLE.
  - START is ignored in DONE; it is accepted from IDLE one cycle later at the earliest.
- START while BUSY is ignored; flags latched at START do not change mid-macroblock.
- ABORT in any non-IDLE state:
  - -> IDLE next cycle, counters cleared, no MB_DONE.
  - ABORT wins over a simultaneous transfer (that transfer still counts as accepted downstream, but the sequence ends).
- Index counters wrap to 0 on each type change and never exceed the type's block count.
- When BLK_VALID=0, BLK_TYPE, BLK_IDX, BLK_POS, DC and MAX_COEF read 0.
- Total descriptors per macroblock: 16 + INTRA16 + CHROMA_EN*(2 + 2*CHROMA_BLKS).

Test Plan:
1. Reset, then START with INTRA16=1, CHROMA_EN=1, BLK_ACK held 1 (START at cycle 0).
   - Required: 27 consecutive valid cycles 1..27, in order LUMA_DC(MAX 16, DC=1), 16×LUMA_AC(MAX 15), CB_DC, CR_DC(MAX 4, DC=1), 4×CB_AC, 4×CR_AC(MAX 15).
   - Required: MB_DONE=1 at cycle 28 only; BUSY=0 at cycle 29.
2. START with INTRA16=0, CHROMA_EN=0, BLK_ACK=1.
   - Required: 16 LUMA4x4 descriptors, cycles 1..16, MAX_COEF=16, DC=0.
   - Required: BLK_POS sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15; MB_DONE at cycle 17.
3. Backpressure: hold BLK_ACK=0 for 5 cycles on LUMA idx 3, then release.
   - Required: descriptor is stable for all 5 stall cycles, BLK_IDX=3 is never skipped or duplicated, and the total count is unchanged.
4. Assert ABORT during CAC at CB_AC idx 2.
   - Required: BUSY=0 and BLK_VALID=0 next cycle, no MB_DONE.
   - Required: a following START restarts from the first descriptor with idx 0.
5. Assert RESET mid-LUMA (idx 7) together with BLK_ACK=1 and START=1.
   - Required: all outputs 0 the next cycle, state IDLE; START is not honoured on that cycle.
6. Pulse START while BUSY and change INTRA16 mid-macroblock.
   - Required: no effect on the sequence or descriptor types.
   - Required: START asserted on the MB_DONE cycle is ignored; START one cycle later is accepted.
